// File: rtl/spi_slave_responder.sv
// ============================================================================
// Module   : spi_slave_responder
// Brief    : Oversampled SPI mode-0 slave with READ/WRITE/ID commands over a
//            small byte register file, plus a combinational host read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_responder #(
  parameter int          DEPTH   = 16,
  parameter int          ADDR_W  = 4,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic              spi_sck,
  input  logic              spi_csb,
  input  logic              spi_sdi,
  output logic              spi_sdo,
  output logic              spi_sdoenb,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              cmd_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_WR_DATA = 3'd3,
    S_RD_DATA = 3'd4,
    S_ID_OUT  = 3'd5,
    S_IGNORE  = 3'd6
  } state_t;

  localparam logic [7:0] C_CMD_READ  = 8'h03;
  localparam logic [7:0] C_CMD_WRITE = 8'h02;
  localparam logic [7:0] C_CMD_ID    = 8'h9F;

  state_t            r_state, w_state_nxt;
  logic              r_sck_meta, r_sck_sync, r_sck_prev;
  logic              r_csb_meta, r_csb_sync, r_csb_prev;
  logic              r_sdi_meta, r_sdi_sync;
  logic [2:0]        r_bitcnt;
  logic [6:0]        r_shift;
  logic [7:0]        r_out;
  logic              r_sdoenb;
  logic              r_is_rd;
  logic              r_cmd_ok;
  logic              r_first;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_mem [DEPTH];

  logic              w_rise, w_fall, w_csb_rise, w_last_bit;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_ptr_inc;

  assign w_rise     = r_sck_sync & ~r_sck_prev;
  assign w_fall     = ~r_sck_sync & r_sck_prev;
  assign w_csb_rise = r_csb_sync & ~r_csb_prev;
  assign w_byte     = {r_shift, r_sdi_sync};
  assign w_last_bit = w_rise && (r_bitcnt == 3'd7);
  assign w_ptr_inc  = r_ptr + ADDR_W'(1);

  assign spi_sdo    = r_out[7];
  assign spi_sdoenb = r_sdoenb;
  assign reg_rdata  = r_mem[reg_addr];

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_csb_meta <= 1'b1;
      r_csb_sync <= 1'b1;
      r_csb_prev <= 1'b1;
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      r_sck_meta <= spi_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_csb_meta <= spi_csb;
      r_csb_sync <= r_csb_meta;
      r_csb_prev <= r_csb_sync;
      r_sdi_meta <= spi_sdi;
      r_sdi_sync <= r_sdi_meta;
      r_state    <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_csb_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (!r_csb_sync) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_last_bit) begin
            if (w_byte == C_CMD_READ || w_byte == C_CMD_WRITE) w_state_nxt = S_ADDR;
            else if (w_byte == C_CMD_ID)                        w_state_nxt = S_ID_OUT;
            else                                                w_state_nxt = S_IGNORE;
          end
        end
        S_ADDR: if (w_last_bit) w_state_nxt = r_is_rd ? S_RD_DATA : S_WR_DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_bitcnt  <= 3'd0;
      r_shift   <= 7'd0;
      r_out     <= 8'h00;
      r_sdoenb  <= 1'b1;
      r_is_rd   <= 1'b0;
      r_cmd_ok  <= 1'b0;
      r_first   <= 1'b0;
      r_ptr     <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      cmd_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      cmd_done  <= 1'b0;
      if (w_csb_rise) begin
        // Any partially shifted byte dies here; only whole bytes ever commit.
        r_bitcnt <= 3'd0;
        r_out    <= 8'h00;
        r_sdoenb <= 1'b1;
        cmd_done <= r_cmd_ok;
        r_cmd_ok <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_bitcnt <= 3'd0;
      end else begin
        if (w_rise) begin
          r_bitcnt <= r_bitcnt + 3'd1;
          r_shift  <= w_byte[6:0];
        end
        if (w_last_bit) begin
          case (r_state)
            S_CMD: begin
              r_is_rd  <= (w_byte == C_CMD_READ);
              r_cmd_ok <= (w_byte inside {C_CMD_READ, C_CMD_WRITE, C_CMD_ID});
            end
            S_ADDR: begin
              r_ptr   <= w_byte[ADDR_W-1:0];
              r_first <= 1'b1;
            end
            S_WR_DATA: begin
              r_mem[r_ptr] <= w_byte;
              wr_strobe    <= 1'b1;
              wr_addr      <= r_ptr;
              r_ptr        <= w_ptr_inc;
            end
            default: ;
          endcase
        end
        // Falls with bitcnt==0 in an output state are byte boundaries.
        if (w_fall && (r_state == S_RD_DATA || r_state == S_ID_OUT)) begin
          if (r_bitcnt == 3'd0) begin
            r_sdoenb <= 1'b0;
            if (r_state == S_ID_OUT) begin
              r_out <= ID_BYTE;
            end else if (r_first) begin
              r_out   <= r_mem[r_ptr];
              r_first <= 1'b0;
            end else begin
              r_out <= r_mem[w_ptr_inc];
              r_ptr <= w_ptr_inc;
            end
          end else begin
            r_out <= {r_out[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
// ============================================================================
// Module   : tb_spi_slave_responder
// Brief    : Directed + randomized SPI transactions checked against a
//            byte-level model of the register file and command protocol.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_responder;

  localparam int HALF = 6;

  logic       core_clk, core_rstn;
  logic       spi_sck, spi_csb, spi_sdi;
  logic       spi_sdo, spi_sdoenb;
  logic [3:0] reg_addr;
  logic [7:0] reg_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic       cmd_done;

  spi_slave_responder #(.DEPTH(16), .ADDR_W(4), .ID_BYTE(8'hA5)) dut (
    .core_clk   (core_clk),
    .core_rstn  (core_rstn),
    .spi_sck    (spi_sck),
    .spi_csb    (spi_csb),
    .spi_sdi    (spi_sdi),
    .spi_sdo    (spi_sdo),
    .spi_sdoenb (spi_sdoenb),
    .reg_addr   (reg_addr),
    .reg_rdata  (reg_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .cmd_done   (cmd_done)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  logic       in_txn = 1'b1;
  logic [7:0] model_mem [16];
  int         exp_wr_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  // Expected MISO byte and enable for byte index k of a transaction.
  function automatic void exp_out(input logic [7:0] cmd, input logic [7:0] adr, input int k,
                                  output logic oe_n, output logic [7:0] byt);
    oe_n = 1'b1;
    byt  = 8'h00;
    if (cmd == 8'h03 && k >= 2) begin
      oe_n = 1'b0;
      byt  = model_mem[(int'(adr[3:0]) + k - 2) % 16];
    end else if (cmd == 8'h9F && k >= 1) begin
      oe_n = 1'b0;
      byt  = 8'hA5;
    end
  endfunction

  // Compare process: strobes, cmd_done and idle-time outputs every cycle.
  always @(negedge core_clk) begin
    if (core_rstn) begin
      if (wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_wr_strobe", 32'd1, 32'd0);
        end else begin
          int a;
          a = exp_wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(a));
        end
      end
      if (cmd_done) done_cnt++;
      if (!in_txn) begin
        check("idle_sdoenb", 32'(spi_sdoenb), 32'd1);
        check("idle_sdo", 32'(spi_sdo), 32'd0);
        check("reg_rdata", 32'(reg_rdata), 32'(model_mem[reg_addr]));
      end
    end
  end

  task automatic drive_bit(input logic b);
    spi_sdi = b;
    waitc(HALF);
    spi_sck = 1'b1;
    waitc(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b[$], input int nbits, output logic [7:0] cap[$]);
    logic [7:0] cmd, adr, eb, cb;
    logic       oe_n, exp_done;
    int         wa[$];
    logic [7:0] wd[$];
    cap.delete();
    cmd = b[0];
    adr = (b.size() > 1) ? b[1] : 8'h00;
    exp_done = (nbits >= 8) && (cmd inside {8'h02, 8'h03, 8'h9F});
    if (cmd == 8'h02) begin
      for (int k = 2; k < b.size(); k++) begin
        if (nbits >= 8 * (k + 1)) begin
          wa.push_back((int'(adr[3:0]) + k - 2) % 16);
          wd.push_back(b[k]);
          exp_wr_q.push_back((int'(adr[3:0]) + k - 2) % 16);
        end
      end
    end
    in_txn   = 1'b1;
    done_cnt = 0;
    cb       = 8'h00;
    spi_csb  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int k, j;
      k = i / 8;
      j = i % 8;
      spi_sdi = b[k][7-j];
      waitc(HALF);
      exp_out(cmd, adr, k, oe_n, eb);
      check("sdoenb_at_rise", 32'(spi_sdoenb), 32'(oe_n));
      check("sdo_at_rise", 32'(spi_sdo), oe_n ? 32'd0 : 32'(eb[7-j]));
      cb = {cb[6:0], spi_sdo};
      if (j == 7) cap.push_back(cb);
      spi_sck = 1'b1;
      waitc(HALF);
      spi_sck = 1'b0;
    end
    waitc(HALF);
    spi_csb = 1'b1;
    waitc(10);
    for (int n = 0; n < wa.size(); n++) model_mem[wa[n]] = wd[n];
    check("cmd_done_pulses", 32'(done_cnt), 32'(exp_done));
    check("wr_strobes_all_seen", 32'(exp_wr_q.size()), 32'd0);
    exp_wr_q.delete();
    in_txn = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
    reg_addr = a;
    #1;
    check(name, 32'(reg_rdata), 32'(exp));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx[$];
    logic [7:0] cap[$];
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    core_rstn = 1'b0;
    spi_sck   = 1'b0;
    spi_csb   = 1'b1;
    spi_sdi   = 1'b0;
    reg_addr  = 4'd0;
    waitc(3);
    check("rst_sdoenb", 32'(spi_sdoenb), 32'd1);
    check("rst_sdo", 32'(spi_sdo), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_cmd_done", 32'(cmd_done), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    for (int a = 0; a < 16; a++) peek(4'(a), 8'h00, "rst_mem");
    core_rstn = 1'b1;
    waitc(3);
    in_txn = 1'b0;
    waitc(4);

    // Write then read back
    tx = {8'h02, 8'h05, 8'h93, 8'h01};
    xfer(tx, 32, cap);
    peek(4'd5, 8'h93, "write_mem5");
    peek(4'd6, 8'h01, "write_mem6");
    tx = {8'h03, 8'h05, 8'h00, 8'h00};
    xfer(tx, 32, cap);
    check("read_byte0", 32'(cap[2]), 32'h93);
    check("read_byte1", 32'(cap[3]), 32'h01);

    // Pointer wrap
    tx = {8'h02, 8'h0F, 8'h63, 8'h57, 8'hB5};
    xfer(tx, 40, cap);
    peek(4'd15, 8'h63, "wrap_mem15");
    peek(4'd0, 8'h57, "wrap_mem0");
    peek(4'd1, 8'hB5, "wrap_mem1");
    tx = {8'h03, 8'h0F, 8'h00, 8'h00, 8'h00};
    xfer(tx, 40, cap);
    check("wrap_read0", 32'(cap[2]), 32'h63);
    check("wrap_read1", 32'(cap[3]), 32'h57);
    check("wrap_read2", 32'(cap[4]), 32'hB5);

    // ID
    tx = {8'h9F, 8'h00, 8'h00, 8'h00};
    xfer(tx, 32, cap);
    check("id0", 32'(cap[1]), 32'hA5);
    check("id1", 32'(cap[2]), 32'hA5);
    check("id2", 32'(cap[3]), 32'hA5);

    // Aborted write and unknown command
    tx = {8'h02, 8'h03, 8'hFF};
    xfer(tx, 21, cap);
    peek(4'd3, 8'h00, "abort_mem3");
    check("abort_cmd_done", 32'(done_cnt), 32'd1);
    tx = {8'h55, 8'h23, 8'h20};
    xfer(tx, 24, cap);
    check("unknown_cmd_done", 32'(done_cnt), 32'd0);

    // Reset in the middle of a READ data byte
    in_txn  = 1'b1;
    spi_csb = 1'b0;
    tx = {8'h03, 8'h05, 8'h00};
    for (int i = 0; i < 20; i++) drive_bit(tx[i/8][7-(i%8)]);
    waitc(HALF);
    check("pre_reset_sdoenb", 32'(spi_sdoenb), 32'd0);
    core_rstn = 1'b0;
    waitc(2);
    check("midrst_sdoenb", 32'(spi_sdoenb), 32'd1);
    check("midrst_sdo", 32'(spi_sdo), 32'd0);
    for (int a = 0; a < 16; a++) peek(4'(a), 8'h00, "midrst_mem");
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    core_rstn = 1'b1;
    waitc(3);
    spi_csb = 1'b1;
    waitc(10);
    in_txn = 1'b0;
    tx = {8'h02, 8'h00, 8'h20};
    xfer(tx, 24, cap);
    peek(4'd0, 8'h20, "post_reset_mem0");

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      int sel, nb, nbits;
      sel = $urandom_range(0, 3);
      nb  = $urandom_range(1, 5);
      tx.delete();
      case (sel)
        0: tx.push_back(8'h02);
        1: tx.push_back(8'h03);
        2: tx.push_back(8'h9F);
        default: tx.push_back(8'($urandom));
      endcase
      for (int k = 1; k < nb; k++) tx.push_back(8'($urandom));
      nbits = 8 * nb;
      if ($urandom_range(0, 3) == 0) nbits = nbits - $urandom_range(1, 7);
      reg_addr = 4'($urandom);
      xfer(tx, nbits, cap);
      waitc(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
